id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between the decode-stage register file read and the execute stage of the 5-stage MIPS core.
- Captures the Rs/Rt operands, register IDs, immediate and decode control each cycle.
- Performs load-use hazard detection, inserts bubbles on load-use or branch flush, and bypasses same-cycle WB writes into the captured operands.
- Keeps a saturating bubble counter for performance checks.

Parameters:
- COUNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs_data_ID  in  32  Rs operand from register file
- Rt_data_ID  in  32  Rt operand from register file (already byte-masked for sb)
- Rs_ID  in  5  Rs index of decoding instruction
- Rt_ID  in  5  Rt index
- Rd_ID  in  5  Rd index
- Imm_ID  in  16  raw immediate
- ExtOp_ID  in  1  1 = sign-extend immediate, 0 = zero-extend
- UsesRt_ID  in  1  instruction reads Rt as a source
- Ctrl_ID  in  10  {RegDst, ALUSrc, ALUOp[3:0], MemRead, MemWrite, MemtoReg, RegWrite}
- LB_ID  in  1  Load_Byte_control for this instruction
- SB_ID  in  1  Store_Byte_control for this instruction
- Flush_ID  in  1  branch/jump taken; squash the decoding instruction
- RegWrite_WB  in  1  WB stage write enable
- RegWr_ID_WB  in  5  WB destination index
- Write_data_WB  in  32  WB write value
- Clear_count  in  1  synchronous clear of bubble counter
- Stall_ID  out  1  combinational; holds PC and IF/ID when high
- Rs_data_EX  out  32  registered Rs operand
- Rt_data_EX  out  32  registered Rt operand
- Rs_EX, Rt_EX, Rd_EX  out  5 each  registered indices
- Imm_EX  out  32  registered extended immediate
- Ctrl_EX  out  10  registered control (same packing as Ctrl_ID)
- LB_EX, SB_EX  out  1 each  registered byte controls
- Bubble_count  out  COUNT_W  bubbles inserted since reset or clear

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs = 0, including Bubble_count. Ctrl_EX = 0 is a bubble. Release is synchronous to clk.
- Hazard detect (combinational), hz = Ctrl_EX.MemRead & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (UsesRt_ID & Rt_EX == Rt_ID)).
- Stall_ID = hz & ~Flush_ID. Stall_ID is 0 during reset.
- WB bypass: when RegWrite_WB & RegWr_ID_WB != 0 and RegWr_ID_WB equals Rs_ID (or Rt_ID), the captured Rs (or Rt) value is Write_data_WB instead of the register file value.
  - If SB_ID is set, only Write_data_WB[7:0] is bypassed to Rt, zero-extended to 32 bits.
  - Bypass applies to both operands independently.
- Immediate: Imm_EX = ExtOp_ID ? {{16{Imm_ID[15]}}, Imm_ID} : {16'b0, Imm_ID}.
- Per rising edge, priority Flush_ID > hz > normal:
  - Flush: Ctrl_EX, LB_EX, SB_EX = 0. Data and index fields capture normally (don't-care, but deterministic).
  - hz: same as flush; the bubble is inserted and the ID inputs are held upstream by Stall_ID.
  - Normal: all fields capture the ID inputs (after bypass and extension).
- Latency: exactly 1 cycle, ID inputs to EX outputs.
- Bubble_count: +1 on every edge where flush or hz inserts a bubble. Saturates at all-ones with no wrap.
  - Clear_count takes priority over increment: a cycle with both clear and a bubble gives 0.
- A load-use hazard stalls for exactly one cycle: the bubble makes Ctrl_EX.MemRead 0, so hz drops in the next cycle.
- Flush during a stall cycle: Stall_ID drops, a bubble is inserted, and Bubble_count increments once (not twice).
- Reset asserted mid-stall: outputs clear immediately, Stall_ID = 0 after Ctrl_EX clears.
- Index 0 never triggers a hazard or a bypass.

Test Plan:
- Reset then rst_n=1, all ID inputs 0 -> all EX outputs 0, Stall_ID=0, Bubble_count=0.
- Normal capture: Rs_data_ID=32'h0A12, Rt_data_ID=32'h5, Rs_ID=8, Rt_ID=9, Imm_ID=16'hFFF0, ExtOp_ID=1, Ctrl_ID=10'h3FF -> next edge: Rs_data_EX=32'h0A12, Imm_EX=32'hFFFFFFF0, Ctrl_EX=10'h3FF. With ExtOp_ID=0 -> Imm_EX=32'h0000FFF0.
- Load-use: EX holds lw with Rt_EX=8, MemRead=1; ID has Rs_ID=8 -> Stall_ID=1 that cycle; next edge Ctrl_EX=0, Bubble_count=1, Stall_ID=0. Repeat with Rt_EX=0 -> Stall_ID=0.
- WB bypass: RegWrite_WB=1, RegWr_ID_WB=9, Write_data_WB=32'hDEADBEEF, Rt_ID=9, Rt_data_ID=32'h1 -> Rt_data_EX=32'hDEADBEEF. With SB_ID=1 -> 32'h000000EF. With RegWr_ID_WB=0 -> 32'h1.
- Flush plus hazard in the same cycle -> Stall_ID=0, Ctrl_EX=0, Bubble_count +1 only. Flush plus Clear_count -> Bubble_count=0.
- Saturation: COUNT_W=4, 17 consecutive flushes -> Bubble_count=4'hF. Async reset pulse between edges -> outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// This is the ID/EX pipeline register of the 5-stage MIPS core. On every rising
// edge it captures the decode-stage operands, register indices, extended
// immediate and control word. It also performs three jobs around that capture:
//   - Load-use hazard detection. Stall_ID holds the PC and IF/ID while a bubble
//     is inserted.
//   - Bubble insertion on a load-use hazard or on a branch/jump flush.
//   - Bypass of a write-back that lands in the same cycle into the captured
//     operands, because the register file read has already happened.
// A saturating counter records how many bubbles have been inserted.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   Rs_data_ID, Rt_data_ID  register file operands (Rt already byte-masked for sb)
//   Rs_ID, Rt_ID, Rd_ID     register indices of the decoding instruction
//   Imm_ID, ExtOp_ID        raw immediate; 1 = sign-extend, 0 = zero-extend
//   UsesRt_ID               instruction reads Rt as a source
//   Ctrl_ID                 {RegDst, ALUSrc, ALUOp[3:0], MemRead, MemWrite,
//                            MemtoReg, RegWrite}
//   LB_ID, SB_ID            byte load/store controls
//   Flush_ID                squash the decoding instruction
//   RegWrite_WB, RegWr_ID_WB, Write_data_WB   write-back port, used for bypass
//   Clear_count             synchronous clear of Bubble_count
//   Stall_ID                combinational stall request to PC and IF/ID
//   *_EX                    registered execute-stage copies
//   Bubble_count            bubbles inserted since reset or clear (saturating)
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        Rs_data_ID,
  input  logic [31:0]        Rt_data_ID,
  input  logic [4:0]         Rs_ID,
  input  logic [4:0]         Rt_ID,
  input  logic [4:0]         Rd_ID,
  input  logic [15:0]        Imm_ID,
  input  logic               ExtOp_ID,
  input  logic               UsesRt_ID,
  input  logic [9:0]         Ctrl_ID,
  input  logic               LB_ID,
  input  logic               SB_ID,
  input  logic               Flush_ID,
  input  logic               RegWrite_WB,
  input  logic [4:0]         RegWr_ID_WB,
  input  logic [31:0]        Write_data_WB,
  input  logic               Clear_count,
  output logic               Stall_ID,
  output logic [31:0]        Rs_data_EX,
  output logic [31:0]        Rt_data_EX,
  output logic [4:0]         Rs_EX,
  output logic [4:0]         Rt_EX,
  output logic [4:0]         Rd_EX,
  output logic [31:0]        Imm_EX,
  output logic [9:0]         Ctrl_EX,
  output logic               LB_EX,
  output logic               SB_EX,
  output logic [COUNT_W-1:0] Bubble_count
);

  // MemRead sits at bit 3 of the control word.
  logic mem_read_ex;
  logic hz;
  logic bubble;
  logic rs_fwd;
  logic rt_fwd;
  logic [31:0] rs_next;
  logic [31:0] rt_next;
  logic [31:0] imm_next;

  assign mem_read_ex = Ctrl_EX[3];

  // Load-use hazard. Index 0 is hard-wired to zero, so it never conflicts.
  assign hz = mem_read_ex && (Rt_EX != 5'd0) &&
              ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));

  // A flush squashes the instruction anyway, so there is nothing left to stall for.
  assign Stall_ID = hz && !Flush_ID;
  assign bubble   = Flush_ID || hz;

  // Same-cycle write-back bypass. The two operands are handled independently.
  assign rs_fwd = RegWrite_WB && (RegWr_ID_WB != 5'd0) && (RegWr_ID_WB == Rs_ID);
  assign rt_fwd = RegWrite_WB && (RegWr_ID_WB != 5'd0) && (RegWr_ID_WB == Rt_ID);

  assign rs_next = rs_fwd ? Write_data_WB : Rs_data_ID;
  // For sb, the Rt operand only carries the low byte. The bypassed value is
  // narrowed to match the masking the register file path already applied.
  assign rt_next = !rt_fwd ? Rt_data_ID :
                   SB_ID   ? {24'b0, Write_data_WB[7:0]} : Write_data_WB;

  assign imm_next = ExtOp_ID ? {{16{Imm_ID[15]}}, Imm_ID} : {16'b0, Imm_ID};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Rs_data_EX   <= '0;
      Rt_data_EX   <= '0;
      Rs_EX        <= '0;
      Rt_EX        <= '0;
      Rd_EX        <= '0;
      Imm_EX       <= '0;
      Ctrl_EX      <= '0;
      LB_EX        <= 1'b0;
      SB_EX        <= 1'b0;
      Bubble_count <= '0;
    end else begin
      // Data and index fields capture every cycle, including during bubbles.
      // A zero control word keeps them harmless downstream.
      Rs_data_EX <= rs_next;
      Rt_data_EX <= rt_next;
      Rs_EX      <= Rs_ID;
      Rt_EX      <= Rt_ID;
      Rd_EX      <= Rd_ID;
      Imm_EX     <= imm_next;
      Ctrl_EX    <= bubble ? 10'd0 : Ctrl_ID;
      LB_EX      <= bubble ? 1'b0  : LB_ID;
      SB_EX      <= bubble ? 1'b0  : SB_ID;

      if (Clear_count) begin
        Bubble_count <= '0;
      end else if (bubble && (Bubble_count != {COUNT_W{1'b1}})) begin
        Bubble_count <= Bubble_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage with a 4-bit bubble counter, so that
// saturation can be reached quickly. Inputs change 1 ns after each rising
// edge, and outputs are compared at that same point.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   Rs_data_ID, Rt_data_ID;
  logic [4:0]    Rs_ID, Rt_ID, Rd_ID;
  logic [15:0]   Imm_ID;
  logic          ExtOp_ID, UsesRt_ID;
  logic [9:0]    Ctrl_ID;
  logic          LB_ID, SB_ID, Flush_ID;
  logic          RegWrite_WB;
  logic [4:0]    RegWr_ID_WB;
  logic [31:0]   Write_data_WB;
  logic          Clear_count;
  logic          Stall_ID;
  logic [31:0]   Rs_data_EX, Rt_data_EX;
  logic [4:0]    Rs_EX, Rt_EX, Rd_EX;
  logic [31:0]   Imm_EX;
  logic [9:0]    Ctrl_EX;
  logic          LB_EX, SB_EX;
  logic [CW-1:0] Bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_data_ID(Rs_data_ID), .Rt_data_ID(Rt_data_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
    .Imm_ID(Imm_ID), .ExtOp_ID(ExtOp_ID), .UsesRt_ID(UsesRt_ID),
    .Ctrl_ID(Ctrl_ID), .LB_ID(LB_ID), .SB_ID(SB_ID), .Flush_ID(Flush_ID),
    .RegWrite_WB(RegWrite_WB), .RegWr_ID_WB(RegWr_ID_WB),
    .Write_data_WB(Write_data_WB), .Clear_count(Clear_count),
    .Stall_ID(Stall_ID),
    .Rs_data_EX(Rs_data_EX), .Rt_data_EX(Rt_data_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .Imm_EX(Imm_EX), .Ctrl_EX(Ctrl_EX),
    .LB_EX(LB_EX), .SB_EX(SB_EX),
    .Bubble_count(Bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Rs_data_ID = '0; Rt_data_ID = '0; Rs_ID = '0; Rt_ID = '0; Rd_ID = '0;
    Imm_ID = '0; ExtOp_ID = 0; UsesRt_ID = 0; Ctrl_ID = '0; LB_ID = 0; SB_ID = 0;
    Flush_ID = 0; RegWrite_WB = 0; RegWr_ID_WB = '0; Write_data_WB = '0;
    Clear_count = 0;

    // Reset, then release, with all ID inputs at 0.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_rs_data", Rs_data_EX, 32'h0);
    check("rst_ctrl",    32'(Ctrl_EX), 32'h0);
    check("rst_imm",     Imm_EX, 32'h0);
    check("rst_stall",   32'(Stall_ID), 32'h0);
    check("rst_count",   32'(Bubble_count), 32'h0);

    // Normal capture with sign extension.
    Rs_data_ID = 32'h0A12; Rt_data_ID = 32'h5; Rs_ID = 8; Rt_ID = 9; Rd_ID = 7;
    Imm_ID = 16'hFFF0; ExtOp_ID = 1; Ctrl_ID = 10'h3FF;
    step();
    check("cap_rs_data", Rs_data_EX, 32'h0A12);
    check("cap_rt_data", Rt_data_EX, 32'h5);
    check("cap_rs",      32'(Rs_EX), 32'd8);
    check("cap_rt",      32'(Rt_EX), 32'd9);
    check("cap_rd",      32'(Rd_EX), 32'd7);
    check("cap_imm_sx",  Imm_EX, 32'hFFFFFFF0);
    check("cap_ctrl",    32'(Ctrl_EX), 32'h3FF);
    // Rt_EX=9 is a load here, but Rs_ID=8 and UsesRt_ID=0, so there is no hazard.
    check("cap_nostall", 32'(Stall_ID), 32'h0);
    ExtOp_ID = 0; Ctrl_ID = 10'h000;
    step();
    check("cap_imm_zx",  Imm_EX, 32'h0000FFF0);
    check("cap_count0",  32'(Bubble_count), 32'h0);

    // Load-use hazard on Rs.
    Ctrl_ID = 10'h008; Rs_ID = 1; Rt_ID = 8;
    step();
    check("lu_ctrl_lw",  32'(Ctrl_EX), 32'h008);
    Rs_ID = 8; Rt_ID = 2; Ctrl_ID = 10'h001;
    settle();
    check("lu_stall",    32'(Stall_ID), 32'h1);
    step();
    check("lu_bubble",   32'(Ctrl_EX), 32'h0);
    check("lu_count",    32'(Bubble_count), 32'h1);
    check("lu_unstall",  32'(Stall_ID), 32'h0);
    step();
    check("lu_resume",   32'(Ctrl_EX), 32'h001);

    // A load writing index 0 never stalls.
    Ctrl_ID = 10'h008; Rs_ID = 0; Rt_ID = 0;
    step();
    UsesRt_ID = 1; Ctrl_ID = 10'h000;
    settle();
    check("lu_r0_nostall", 32'(Stall_ID), 32'h0);

    // Hazard through Rt, which is gated by UsesRt_ID.
    Ctrl_ID = 10'h008; Rt_ID = 5; UsesRt_ID = 0;
    step();
    Ctrl_ID = 10'h000; Rs_ID = 2; Rt_ID = 5; UsesRt_ID = 1;
    settle();
    check("lu_rt_stall",   32'(Stall_ID), 32'h1);
    UsesRt_ID = 0;
    settle();
    check("lu_rt_nouse",   32'(Stall_ID), 32'h0);
    step();
    check("lu_rt_count",   32'(Bubble_count), 32'h1);

    // Write-back bypass.
    Rs_ID = 3; Rt_ID = 9; Rs_data_ID = 32'h77; Rt_data_ID = 32'h1;
    RegWrite_WB = 1; RegWr_ID_WB = 9; Write_data_WB = 32'hDEADBEEF;
    step();
    check("byp_rt",      Rt_data_EX, 32'hDEADBEEF);
    check("byp_rs_none", Rs_data_EX, 32'h77);
    SB_ID = 1;
    step();
    check("byp_rt_sb",   Rt_data_EX, 32'h000000EF);
    check("byp_sb_ex",   32'(SB_EX), 32'h1);
    SB_ID = 0; RegWr_ID_WB = 0;
    step();
    check("byp_r0",      Rt_data_EX, 32'h1);
    RegWr_ID_WB = 3;
    step();
    check("byp_rs",      Rs_data_EX, 32'hDEADBEEF);
    check("byp_rs_rt",   Rt_data_EX, 32'h1);
    RegWrite_WB = 0; RegWr_ID_WB = 9;
    step();
    check("byp_nowe",    Rt_data_EX, 32'h1);

    // A flush together with a hazard inserts a single bubble.
    Ctrl_ID = 10'h008; Rs_ID = 0; Rt_ID = 4;
    step();
    Rs_ID = 4; Ctrl_ID = 10'h3FF;
    settle();
    check("fl_hz_stall", 32'(Stall_ID), 32'h1);
    Flush_ID = 1;
    settle();
    check("fl_hz_nostall", 32'(Stall_ID), 32'h0);
    step();
    check("fl_hz_ctrl",  32'(Ctrl_EX), 32'h0);
    check("fl_hz_count", 32'(Bubble_count), 32'h2);
    Clear_count = 1;
    step();
    check("fl_clear",    32'(Bubble_count), 32'h0);
    Clear_count = 0; LB_ID = 1;
    step();
    check("fl_count1",   32'(Bubble_count), 32'h1);
    check("fl_lb_sq",    32'(LB_EX), 32'h0);
    Flush_ID = 0;
    step();
    check("lb_ex",       32'(LB_EX), 32'h1);
    check("lb_ctrl",     32'(Ctrl_EX), 32'h3FF);
    LB_ID = 0;

    // Saturation: the count starts at 1, reaches 4'hF after 14 flushes, then holds.
    Flush_ID = 1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 13) check("sat_reach", 32'(Bubble_count), 32'hF);
    end
    check("sat_hold",    32'(Bubble_count), 32'hF);
    Flush_ID = 0;

    // An asynchronous reset in the middle of a stall clears the outputs
    // without waiting for a clock edge.
    Ctrl_ID = 10'h008; Rs_ID = 1; Rt_ID = 8; Rs_data_ID = 32'h1234;
    step();
    Rs_ID = 8; Ctrl_ID = 10'h3FF;
    settle();
    check("ar_stall",    32'(Stall_ID), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_ctrl",     32'(Ctrl_EX), 32'h0);
    check("ar_rs_data",  Rs_data_EX, 32'h0);
    check("ar_rt",       32'(Rt_EX), 32'h0);
    check("ar_count",    32'(Bubble_count), 32'h0);
    check("ar_nostall",  32'(Stall_ID), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_post_ctrl", 32'(Ctrl_EX), 32'h3FF);
    check("ar_post_cnt",  32'(Bubble_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
